// File: rtl/maxpool_2x2_pkg.sv
// Shared constants for the pooling stage: data width, per-layer feature-map
// dimensions, pooled dimensions and a counter-width helper.
package maxpool_2x2_pkg;

   localparam int CONV_BIT_DEF = 12;

   localparam int L1_WIDTH  = 24;
   localparam int L1_HEIGHT = 24;
   localparam int L2_WIDTH  = 8;
   localparam int L2_HEIGHT = 8;

   localparam int L1_POOL_WIDTH  = L1_WIDTH / 2;
   localparam int L1_POOL_HEIGHT = L1_HEIGHT / 2;
   localparam int L2_POOL_WIDTH  = L2_WIDTH / 2;
   localparam int L2_POOL_HEIGHT = L2_HEIGHT / 2;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/maxpool_2x2_pool_line_buffer.sv
// Line buffer holding the horizontal max of each even-row pixel pair until the
// odd row arrives; one write port and one asynchronous read port on one index.
module pool_line_buffer
   import maxpool_2x2_pkg::*;
#(
   parameter int DEPTH = L1_POOL_WIDTH,
   parameter int WIDTH = 3 * CONV_BIT_DEF,
   parameter int AW    = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end

   assign rd_data = mem[addr];

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max pooling over a 3-channel raster stream, no backpressure.
// Optional MAXPOOL_LAST_EN adds frame_last_out flagging the final pooled pixel.
module maxpool_2x2
   import maxpool_2x2_pkg::*;
#(
   parameter int CONV_BIT  = CONV_BIT_DEF,
   parameter int IN_WIDTH  = L1_WIDTH,
   parameter int IN_HEIGHT = L1_HEIGHT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clear,
   input  logic                valid_in,
   input  logic [CONV_BIT-1:0] relu_in_1,
   input  logic [CONV_BIT-1:0] relu_in_2,
   input  logic [CONV_BIT-1:0] relu_in_3,
   output logic [CONV_BIT-1:0] pool_out_1,
   output logic [CONV_BIT-1:0] pool_out_2,
   output logic [CONV_BIT-1:0] pool_out_3,
   output logic                valid_out
`ifdef MAXPOOL_LAST_EN
   ,
   output logic                frame_last_out
`endif
);

   localparam int CW       = cnt_width(IN_WIDTH);
   localparam int RW       = cnt_width(IN_HEIGHT);
   localparam int LB_DEPTH = IN_WIDTH / 2;
   localparam int AW       = cnt_width(LB_DEPTH);
   localparam int DW       = 3 * CONV_BIT;

   if ((IN_WIDTH % 2) != 0 || (IN_HEIGHT % 2) != 0 || IN_WIDTH < 2 || IN_HEIGHT < 2)
   begin : g_bad_dims
      $fatal(1, "maxpool_2x2: IN_WIDTH and IN_HEIGHT must be even and >= 2");
   end

   logic [CW-1:0]       col_cnt;
   logic [RW-1:0]       row_cnt;
   logic [CONV_BIT-1:0] din  [3];
   logic [CONV_BIT-1:0] hold [3];
   logic [CONV_BIT-1:0] lb_ch[3];
   logic [CONV_BIT-1:0] hmax [3];
   logic [CONV_BIT-1:0] wmax [3];
   logic [CONV_BIT-1:0] pool [3];
   logic [DW-1:0]       lb_wr_data;
   logic [DW-1:0]       lb_rd_data;
   logic [AW-1:0]       lb_addr;
   logic                odd_col, odd_row, col_last, row_last, lb_wr_en;

   assign odd_col  = col_cnt[0];
   assign odd_row  = row_cnt[0];
   assign col_last = (col_cnt == CW'(IN_WIDTH - 1));
   assign row_last = (row_cnt == RW'(IN_HEIGHT - 1));
   assign lb_addr  = AW'(col_cnt >> 1);
   assign lb_wr_en = valid_in & ~clear & odd_col & ~odd_row;

   always_comb begin
      din[0] = relu_in_1;
      din[1] = relu_in_2;
      din[2] = relu_in_3;
      for (int i = 0; i < 3; i++) begin
         lb_ch[i] = lb_rd_data[i*CONV_BIT +: CONV_BIT];
         hmax[i]  = (hold[i] > din[i]) ? hold[i] : din[i];
         wmax[i]  = (lb_ch[i] > hmax[i]) ? lb_ch[i] : hmax[i];
      end
      lb_wr_data = {hmax[2], hmax[1], hmax[0]};
   end

   pool_line_buffer #(
      .DEPTH (LB_DEPTH),
      .WIDTH (DW),
      .AW    (AW)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .addr    (lb_addr),
      .wr_data (lb_wr_data),
      .rd_data (lb_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_out <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            hold[i] <= '0;
            pool[i] <= '0;
         end
      end else if (clear) begin
         // Abort drops the partial window; the next beat is pixel (0,0).
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_out <= 1'b0;
         for (int i = 0; i < 3; i++) hold[i] <= '0;
      end else begin
         valid_out <= 1'b0;
         if (valid_in) begin
            if (col_last) begin
               col_cnt <= '0;
               row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
               col_cnt <= col_cnt + 1'b1;
            end
            if (!odd_col) begin
               for (int i = 0; i < 3; i++) hold[i] <= din[i];
            end else if (odd_row) begin
               for (int i = 0; i < 3; i++) pool[i] <= wmax[i];
               valid_out <= 1'b1;
            end
         end
      end
   end

   assign pool_out_1 = pool[0];
   assign pool_out_2 = pool[1];
   assign pool_out_3 = pool[2];

`ifdef MAXPOOL_LAST_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     frame_last_out <= 1'b0;
      else if (clear) frame_last_out <= 1'b0;
      else            frame_last_out <= valid_in & odd_col & odd_row & col_last & row_last;
   end
`endif

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: a 4x4 instance for the hand-worked case and
// a default 24x24 instance for full frames, bubbles, clear and reset recovery.
module tb_maxpool_2x2;

   localparam int W  = 24;
   localparam int H  = 24;
   localparam int CB = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, clear, valid_in, valid_out;
   logic [CB-1:0] relu_in_1, relu_in_2, relu_in_3;
   logic [CB-1:0] pool_out_1, pool_out_2, pool_out_3;
   logic          valid_in_4, valid_out_4;
   logic [CB-1:0] relu4, zero4;
   logic [CB-1:0] pool4_1, pool4_2, pool4_3;
`ifdef MAXPOOL_LAST_EN
   logic          frame_last_out, frame_last_4;
`endif

   maxpool_2x2 #(.CONV_BIT(CB), .IN_WIDTH(W), .IN_HEIGHT(H)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .valid_in   (valid_in),
      .relu_in_1  (relu_in_1),
      .relu_in_2  (relu_in_2),
      .relu_in_3  (relu_in_3),
      .pool_out_1 (pool_out_1),
      .pool_out_2 (pool_out_2),
      .pool_out_3 (pool_out_3),
      .valid_out  (valid_out)
`ifdef MAXPOOL_LAST_EN
      ,
      .frame_last_out (frame_last_out)
`endif
   );

   maxpool_2x2 #(.CONV_BIT(CB), .IN_WIDTH(4), .IN_HEIGHT(4)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .valid_in   (valid_in_4),
      .relu_in_1  (relu4),
      .relu_in_2  (zero4),
      .relu_in_3  (zero4),
      .pool_out_1 (pool4_1),
      .pool_out_2 (pool4_2),
      .pool_out_3 (pool4_3),
      .valid_out  (valid_out_4)
`ifdef MAXPOOL_LAST_EN
      ,
      .frame_last_out (frame_last_4)
`endif
   );

   typedef struct {
      logic [CB-1:0] d1;
      logic [CB-1:0] d2;
      logic [CB-1:0] d3;
      logic          last;
   } exp_t;

   exp_t          sb_q [$];
   logic [CB-1:0] sb4_q[$];
   logic [CB-1:0] img  [3][H][W];
   int            n_err = 0;
   int            n_chk = 0;
   int            n_out = 0;
   int            n_out_4 = 0;
   bit            drive_cmpl = 1'b0;
   bit            drive_cmpl_4 = 1'b0;
   bit            exp_v, exp_v_4;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [CB-1:0] win_max(input int ch, input int r, input int c);
      logic [CB-1:0] m;
      m = img[ch][r-1][c-1];
      if (img[ch][r-1][c] > m) m = img[ch][r-1][c];
      if (img[ch][r][c-1] > m) m = img[ch][r][c-1];
      if (img[ch][r][c]   > m) m = img[ch][r][c];
      return m;
   endfunction

   // A beat driven after edge N completes a window -> valid_out seen after edge N+1.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_v   <= 1'b0;
         exp_v_4 <= 1'b0;
      end else begin
         exp_v   <= drive_cmpl;
         exp_v_4 <= drive_cmpl_4;
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (valid_out !== 1'b0 || exp_v) begin
            check("valid_out", {31'd0, valid_out}, {31'd0, exp_v});
            if (valid_out === 1'b1) begin
               exp_t e;
               n_out++;
               check("sb_nonempty", {31'd0, sb_q.size() > 0}, 32'd1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check("pool_out_1", {20'd0, pool_out_1}, {20'd0, e.d1});
                  check("pool_out_2", {20'd0, pool_out_2}, {20'd0, e.d2});
                  check("pool_out_3", {20'd0, pool_out_3}, {20'd0, e.d3});
`ifdef MAXPOOL_LAST_EN
                  check("frame_last", {31'd0, frame_last_out}, {31'd0, e.last});
`endif
               end
            end
         end
`ifdef MAXPOOL_LAST_EN
         if (frame_last_out === 1'b1 && valid_out !== 1'b1)
            check("frame_last_alone", {31'd0, frame_last_out}, 32'd0);
`endif
         if (valid_out_4 !== 1'b0 || exp_v_4) begin
            check("valid_out_4", {31'd0, valid_out_4}, {31'd0, exp_v_4});
            if (valid_out_4 === 1'b1) begin
               n_out_4++;
               check("sb4_nonempty", {31'd0, sb4_q.size() > 0}, 32'd1);
               if (sb4_q.size() > 0) check("pool4_1", {20'd0, pool4_1}, {20'd0, sb4_q.pop_front()});
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input int r, input int c, input logic [CB-1:0] a,
                       input logic [CB-1:0] b, input logic [CB-1:0] d, input bit clr);
      valid_in  = 1'b1;
      clear     = clr;
      relu_in_1 = a;
      relu_in_2 = b;
      relu_in_3 = d;
      img[0][r][c] = a;
      img[1][r][c] = b;
      img[2][r][c] = d;
      if (!clr && (r % 2 == 1) && (c % 2 == 1)) begin
         exp_t e;
         e.d1   = win_max(0, r, c);
         e.d2   = win_max(1, r, c);
         e.d3   = win_max(2, r, c);
         e.last = (r == H - 1) && (c == W - 1);
         sb_q.push_back(e);
         drive_cmpl = 1'b1;
      end
      @(posedge clk);
      #1;
      valid_in   = 1'b0;
      clear      = 1'b0;
      drive_cmpl = 1'b0;
      // Junk on idle cycles must not disturb anything.
      relu_in_1  = CB'($urandom);
      relu_in_2  = CB'($urandom);
      relu_in_3  = CB'($urandom);
   endtask

   task automatic pulse_reset();
      idle(2);
      rst_n = 1'b0;
      #1;
      check("rst_pool_out_1", {20'd0, pool_out_1}, 32'd0);
      check("rst_pool_out_2", {20'd0, pool_out_2}, 32'd0);
      check("rst_pool_out_3", {20'd0, pool_out_3}, 32'd0);
      check("rst_valid_out", {31'd0, valid_out}, 32'd0);
      check("rst_sb_drained", sb_q.size(), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // mode 0: ramp, 1: per-channel constants, 2: random; stop_kind 1 = clear, 2 = reset.
   task automatic run_frame(input int mode, input int max_gap,
                            input int stop_kind, input int stop_r, input int stop_c);
      logic [CB-1:0] a, b, d;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            case (mode)
               0: begin a = CB'(r * W + c); b = a; d = a; end
               1: begin a = 12'hFFF; b = 12'h000; d = (r % 2 == 0) ? 12'h800 : 12'h001; end
               default: begin
                  a = CB'($urandom_range(0, 4095));
                  b = CB'($urandom_range(0, 4095));
                  d = CB'($urandom_range(0, 4095));
               end
            endcase
            if (stop_kind != 0 && r == stop_r && c == stop_c) begin
               if (stop_kind == 1) beat(r, c, a, b, d, 1'b1);
               else                pulse_reset();
               return;
            end
            beat(r, c, a, b, d, 1'b0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
         end
      end
   endtask

   task automatic frame_done(input string tag, input int expect_out);
      idle(3);
      check(tag, n_out, expect_out);
      check({tag, "_sb_empty"}, sb_q.size(), 32'd0);
      n_out = 0;
   endtask

   initial begin
      logic [CB-1:0] img4 [4][4];
      logic [CB-1:0] exp4 [4];
      int            k;
      img4 = '{'{12'd1, 12'd5, 12'd2, 12'd0}, '{12'd3, 12'd4, 12'd9, 12'd1},
               '{12'd0, 12'd0, 12'd7, 12'd7}, '{12'd8, 12'd2, 12'd6, 12'd3}};
      exp4 = '{12'd5, 12'd9, 12'd8, 12'd7};
      rst_n = 1'b0; clear = 1'b0; valid_in = 1'b0; valid_in_4 = 1'b0;
      relu_in_1 = '0; relu_in_2 = '0; relu_in_3 = '0; relu4 = '0; zero4 = '0;
      #1;
      check("init_pool_out_1", {20'd0, pool_out_1}, 32'd0);
      check("init_valid_out", {31'd0, valid_out}, 32'd0);
      check("init_pool4_1", {20'd0, pool4_1}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      k = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            valid_in_4 = 1'b1;
            relu4      = img4[r][c];
            if (r % 2 == 1 && c % 2 == 1) begin
               sb4_q.push_back(exp4[k]);
               k++;
               drive_cmpl_4 = 1'b1;
            end
            @(posedge clk);
            #1;
            valid_in_4   = 1'b0;
            drive_cmpl_4 = 1'b0;
         end
      end
      idle(3);
      check("n_out_4x4", n_out_4, 32'd4);
      check("sb4_empty", sb4_q.size(), 32'd0);

      run_frame(0, 0, 0, 0, 0);
      run_frame(0, 0, 0, 0, 0);
      frame_done("n_out_two_ramp_frames", 2 * (W / 2) * (H / 2));

      run_frame(0, 3, 0, 0, 0);
      frame_done("n_out_bubbles", (W / 2) * (H / 2));

      run_frame(1, 0, 0, 0, 0);
      frame_done("n_out_channels", (W / 2) * (H / 2));

      run_frame(2, 1, 1, 5, 7);
      check("sb_empty_after_clear", sb_q.size(), 32'd0);
      n_out = 0;
      run_frame(0, 0, 0, 0, 0);
      frame_done("n_out_after_clear", (W / 2) * (H / 2));

      run_frame(2, 0, 2, 10, 3);
      n_out = 0;
      run_frame(2, 2, 0, 0, 0);
      frame_done("n_out_after_reset", (W / 2) * (H / 2));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
